uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus of the tt_um_examplep top level between two internal write requesters (W0, W1).
- When no requester owns the bus, it is released (pads as inputs) and uio_in is sampled for the core.
- Grants are round-robin, bursts are bounded, and a mandatory bus-turnaround gap separates any two drive periods.
- Instantiated directly inside tt_um_examplep, between the core logic and the uio_out/uio_oe/uio_in pins.

---
 rtl/tt_uio_pkg.sv | 19 +
 rtl/uio_bus_arbiter_rr_arb2.sv | 14 +
 rtl/uio_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_uio_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_uio_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package tt_uio_pkg;

    localparam int UIO_W = 8;
    localparam int NREQ  = 2;

    localparam logic [UIO_W-1:0] OE_ALL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    function automatic logic [NREQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not own last wins.
module rr_arb2
    import tt_uio_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic            i_last_owner,
    output logic            o_valid,
    output logic            o_winner
);

    assign o_valid  = |i_req;
    assign o_winner = (&i_req) ? ~i_last_owner : i_req[1];

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the bidirectional uio pad bus between two write requesters,
// with bounded round-robin bursts and a forced turnaround gap.
module uio_bus_arbiter
    import tt_uio_pkg::*;
#(
    parameter int               MAX_BURST   = 4,
    parameter int               TURN_CYCLES = 1,
    parameter logic [UIO_W-1:0] OE_MASK     = OE_ALL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [NREQ-1:0]  req,
    input  logic [UIO_W-1:0] wdata0,
    input  logic [UIO_W-1:0] wdata1,
    input  logic [NREQ-1:0]  last,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    input  logic [UIO_W-1:0] uio_in,
    output logic [UIO_W-1:0] uio_out,
    output logic [UIO_W-1:0] uio_oe,
    output logic [UIO_W-1:0] rdata,
    output logic             rvalid
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic             r_last_owner;
    logic [3:0]       r_beat_cnt;
    logic [2:0]       r_turn_cnt;
    logic [UIO_W-1:0] r_uio_out;
    logic [UIO_W-1:0] r_uio_oe;
    logic [UIO_W-1:0] r_rdata;
    logic             r_rvalid;

    logic             w_arb_valid;
    logic             w_winner;
    logic             w_own;
    logic [NREQ-1:0]  w_ack;
    logic             w_beat;
    logic             w_cap;
    logic             w_end;
    logic [UIO_W-1:0] w_wdata_own;

    rr_arb2 u_rr_arb2 (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_valid      (w_arb_valid),
        .o_winner     (w_winner)
    );

    // With ena low no beat may be accepted, so ack is gated too.
    assign w_own       = r_gnt[1];
    assign w_ack       = r_gnt & req & {NREQ{ena}};
    assign w_beat      = |w_ack;
    assign w_wdata_own = w_own ? wdata1 : wdata0;
    assign w_cap       = (r_beat_cnt == 4'(MAX_BURST - 1));
    assign w_end       = ~ena | ~req[w_own]
                       | (w_beat & (last[w_own] | w_cap));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (ena & w_arb_valid) w_state_nxt = GRANT;
            GRANT:   if (w_end) w_state_nxt = TURN;
            TURN:    if (r_turn_cnt <= 3'd1) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= '0;
            r_last_owner <= 1'b1;
            r_beat_cnt   <= '0;
            r_turn_cnt   <= '0;
            r_uio_out    <= '0;
            r_uio_oe     <= '0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rdata  <= uio_in;
                    r_rvalid <= ena;
                    if (ena & w_arb_valid) begin
                        r_gnt        <= onehot2(w_winner);
                        r_last_owner <= w_winner;
                        r_beat_cnt   <= '0;
                        r_rvalid     <= 1'b0;
                    end
                end
                GRANT: begin
                    r_rvalid <= 1'b0;
                    if (w_beat) begin
                        r_uio_out  <= w_wdata_own;
                        r_uio_oe   <= OE_MASK;
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                    if (w_end) begin
                        r_gnt      <= '0;
                        r_turn_cnt <= 3'(TURN_CYCLES);
                    end
                end
                TURN: begin
                    r_uio_oe   <= '0;
                    r_uio_out  <= '0;
                    r_rvalid   <= 1'b0;
                    r_turn_cnt <= r_turn_cnt - 3'd1;
                end
                default: begin
                    r_gnt    <= '0;
                    r_uio_oe <= '0;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = w_ack;
    assign uio_out = r_uio_out;
    assign uio_oe  = r_uio_oe;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: requester queues drive the bus and a
// transaction-level model predicts grants, burst lengths and pin data.
module tb_uio_bus_arbiter;

    localparam int MAXB  = 4;
    localparam int TURNC = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] req;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] last;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] rdata;
    logic       rvalid;

    always #5 clk = ~clk;

    uio_bus_arbiter #(
        .MAX_BURST   (MAXB),
        .TURN_CYCLES (TURNC),
        .OE_MASK     (8'hFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .last    (last),
        .gnt     (gnt),
        .ack     (ack),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .rdata   (rdata),
        .rvalid  (rvalid)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int         checks = 0;
    int         failures = 0;
    logic [1:0] prev_gnt = 2'b00;
    int         beats = 0;
    int         exp_beats = 0;
    int         zero_run = 0;
    bit         seen_drive = 1'b0;
    logic       last_gowner = 1'b1;
    int         gorder[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req[0]  = (q0.size() > 0);
        req[1]  = (q1.size() > 0);
        wdata0  = (q0.size() > 0) ? q0[0].d : 8'($urandom);
        wdata1  = (q1.size() > 0) ? q1[0].d : 8'($urandom);
        last[0] = (q0.size() > 0) ? q0[0].l : 1'($urandom);
        last[1] = (q1.size() > 0) ? q1[0].l : 1'($urandom);
        #1;
    endtask

    // Beats a fresh grant should carry: up to and including the first
    // last-flagged beat, capped at the burst limit.
    function automatic int blen(input logic o);
        int    n;
        int    sz;
        beat_t b;
        n  = 0;
        sz = o ? q1.size() : q0.size();
        for (int k = 0; k < sz; k++) begin
            b = o ? q1[k] : q0[k];
            n++;
            if (b.l) break;
        end
        return (n > MAXB) ? MAXB : n;
    endfunction

    task automatic step();
        logic [1:0] a;
        logic [1:0] r;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       o;
        logic       w;
        a  = ack;
        r  = req;
        d0 = wdata0;
        d1 = wdata1;
        @(posedge clk);
        #1;
        if (a != 2'b00) begin
            o = a[1];
            chk("ack_onehot", 32'(a == 2'b01 || a == 2'b10), 1);
            chk("pin_data", uio_out, o ? d1 : d0);
            chk("pin_oe", uio_oe, 8'hFF);
            beats++;
            if (o) void'(q1.pop_front());
            else   void'(q0.pop_front());
        end
        if (prev_gnt == 2'b00 && gnt != 2'b00) begin
            o = gnt[1];
            w = (r == 2'b11) ? ~last_gowner : r[1];
            chk("gnt_onehot", 32'(gnt == 2'b01 || gnt == 2'b10), 1);
            chk("rr_winner", o, w);
            last_gowner = o;
            gorder.push_back(int'(o));
            beats     = 0;
            exp_beats = blen(o);
        end
        if (prev_gnt != 2'b00 && gnt == 2'b00)
            chk("burst_len", beats, exp_beats);
        chk("oe_legal", 32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 1);
        if (uio_oe == 8'hFF) begin
            if (seen_drive && zero_run > 0)
                chk("turn_gap", 32'(zero_run >= TURNC), 1);
            zero_run   = 0;
            seen_drive = 1'b1;
        end else begin
            zero_run++;
        end
        prev_gnt = gnt;
        drive();
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || gnt != 2'b00) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < maxc), 1);
        repeat (4) step();
    endtask

    task automatic push(input logic o, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        if (o) q1.push_back(b);
        else   q0.push_back(b);
    endtask

    initial begin
        int n;
        logic [7:0] v;
        rst_n  = 1'b0;
        ena    = 1'b0;
        uio_in = 8'h00;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_out", uio_out, 0);
        chk("rst_oe", uio_oe, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle sampling
        ena    = 1'b1;
        uio_in = 8'h5C;
        drive();
        step();
        chk("idle_rdata", rdata, 8'h5C);
        chk("idle_rvalid", rvalid, 1);
        ena    = 1'b0;
        v      = 8'($urandom);
        uio_in = v;
        #1;
        step();
        chk("idle_rvalid_off", rvalid, 0);
        chk("idle_rdata_off", rdata, v);
        ena = 1'b1;

        // single burst on W0
        push(1'b0, 8'hA1, 1'b0);
        push(1'b0, 8'hA2, 1'b0);
        push(1'b0, 8'hA3, 1'b1);
        drive();
        step();
        chk("sb_gnt", gnt, 2'b01);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sb_out", uio_out, 8'hA1 + 8'(k));
            chk("sb_oe", uio_oe, 8'hFF);
        end
        chk("sb_gnt_end", gnt, 2'b00);
        step();
        chk("sb_turn_oe", uio_oe, 8'h00);
        chk("sb_turn_rvalid", rvalid, 0);
        step();
        chk("sb_idle_rvalid", rvalid, 1);

        // burst cap on W1
        gorder.delete();
        for (int k = 0; k < 6; k++) push(1'b1, 8'h10 + 8'(k), 1'b0);
        drive();
        drain(60);
        chk("cap_ngrants", gorder.size(), 2);
        for (int k = 0; k < gorder.size(); k++) chk("cap_owner", gorder[k], 1);

        // contention, 2-beat bursts
        gorder.delete();
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 8'($urandom), 1'b0);
            push(1'b0, 8'($urandom), 1'b1);
            push(1'b1, 8'($urandom), 1'b0);
            push(1'b1, 8'($urandom), 1'b1);
        end
        drive();
        drain(80);
        chk("cont_ngrants", gorder.size(), 4);
        for (int k = 0; k < gorder.size(); k++) chk("cont_order", gorder[k], k % 2);

        // randomized bursts on both requesters
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int o = 0; o < 2; o++) begin
                n = int'($urandom_range(0, 7));
                for (int k = 0; k < n; k++)
                    push(1'(o), 8'($urandom), ($urandom_range(0, 2) == 0));
            end
            uio_in = 8'($urandom);
            drive();
            drain(200);
        end

        // abort by ena after the 2nd beat
        for (int k = 0; k < 5; k++) push(1'b0, 8'($urandom), 1'b0);
        drive();
        n = 0;
        while (!(beats == 2 && gnt == 2'b01) && n < 30) begin
            step();
            n++;
        end
        chk("abort_reach", 32'(n < 30), 1);
        ena       = 1'b0;
        exp_beats = 2;
        #1;
        chk("abort_no_ack", ack, 0);
        step();
        chk("abort_gnt", gnt, 2'b00);
        step();
        chk("abort_oe", uio_oe, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_nogrant", gnt, 2'b00);
            chk("abort_rvalid", rvalid, 0);
        end
        ena = 1'b1;
        drive();
        drain(60);

        // async reset mid-burst
        for (int k = 0; k < 4; k++) push(1'b0, 8'($urandom), 1'b0);
        drive();
        n = 0;
        while (uio_oe != 8'hFF && n < 20) begin
            step();
            n++;
        end
        chk("ar_reach", 32'(n < 20), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_oe", uio_oe, 0);
        chk("ar_out", uio_out, 0);
        chk("ar_gnt", gnt, 0);
        chk("ar_rvalid", rvalid, 0);
        q0.delete();
        q1.delete();
        prev_gnt    = 2'b00;
        beats       = 0;
        zero_run    = 0;
        seen_drive  = 1'b0;
        last_gowner = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 8'($urandom), 1'b0);
        push(1'b0, 8'($urandom), 1'b1);
        push(1'b1, 8'($urandom), 1'b0);
        push(1'b1, 8'($urandom), 1'b1);
        drive();
        step();
        chk("ar_first_w0", gnt, 2'b01);
        drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
